dcpu16_ctlx: RTL and testbench
==============================

Name: dcpu16_ctlx

Overview:
Parametrised successor to the DCPU-16 four-phase control sequencer. It latches instruction words, decodes operand fields into register-file read and write addresses, and stages CC-gated writeback. Compared with the fixed 16-bit controller it adds:
- a fetch handshake that stalls the phase counter until the bus acknowledges;
- IF-class conditional skip, which replaces the next instruction with a NOP;
- write-enable gating during a skip.

It sits between the fetch bus and the datapath/register file.

Parameters:
DW, 16, instruction word width (DW = 2*FW + OPW)
OPW, 4, opcode field width (ireg[OPW-1:0])
FW, 6, operand field width (A = ireg[OPW+FW-1:OPW], B = upper FW bits)
RAW, 3, register address width (RAW < FW)
NOPI, 16'h0001, word substituted for squashed instructions (SET A,A)
BRA_CODE, 6'h10, A-field value flagging a branch (PC destination)
IFBASE, 4'hC, lowest conditional opcode; opcodes IFBASE..2^OPW-1 are conditionals

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
ena  in  1  global advance enable; low freezes all state
f_dti  in  DW  fetched instruction word
f_ack  in  1  fetch acknowledge, sampled in phase 2
f_stb  out  1  fetch request, high while pha==2
CC  in  1  condition result from ALU, sampled in phase 0
wpc  in  1  PC was written (taken branch); squash the word being fetched
ireg  out  DW  latched instruction
pha  out  2  current phase 0..3
opc  out  OPW  opcode of the instruction in execute
rra  out  RAW  register read address
rwa  out  RAW  register write address
rwe  out  1  register write enable (single-cycle pulse)
bra  out  1  instruction in execute targets PC
skp  out  1  skip pending; next fetched word will be squashed

Behaviour:
- Reset (rst low, async): pha, ireg, opc, rra, rwa, rwe, bra, skp and the internal _rwa/_rwe all go to 0.
- Advance condition: adv = ena & ~(pha==2 & ~f_ack). Every register updates only when adv is high. Phase wraps 3 -> 0.
- Stall: at pha==2 with f_ack low, f_stb stays high and every output holds. There is no timeout.
- f_stb = (pha==2), combinational, independent of ena.
- Phase 2 with adv:
  - ireg <= (wpc | skp) ? NOPI : f_dti.
  - opc <= old ireg[OPW-1:0].
  - bra <= (old A field == BRA_CODE).
  - If skp was set, skp <= 0 (one word squashed per skip).
  - wpc and skp together: a single NOPI, and skp clears.
- rra, updated on adv:
  - phases 0 and 2 -> B[RAW-1:0];
  - phases 1 and 3 -> A[RAW-1:0];
  - both fields taken from the current ireg.
- Writeback, on adv:
  - Phase 0: rwa <= _rwa; rwe <= _rwe & CC & ~skp.
  - Also phase 0: _rwa <= A[RAW-1:0]; _rwe <= (A[FW-1:RAW]==0) & (opc != 0) & (opc < IFBASE).
  - Other phases: rwe <= 0; rwa holds.
- Skip:
  - In phase 0 with adv, if opc >= IFBASE and CC==0, set skp <= 1.
  - skp and the phase-2 clear cannot collide: they occur in different phases.
- Width rule: comparisons are zero-extended to the field width. The BRA_CODE compare uses the full FW bits.
- Reset during a stall or a pending skip: all state clears; the next fetch is not squashed.
- ena low during a stall: the stall is held, and f_ack is ignored until ena is high.

Decomposition:
- Shared package dcpu16_pkg holds:
  - the default widths (DW, OPW, FW, RAW);
  - NOPI;
  - BRA_CODE;
  - IFBASE;
  - phase constants PH_EXA=0, PH_EXB=1, PH_FET=2, PH_DEC=3.
- One sub-module, dcpu16_ctlx_dec: a combinational field splitter producing the A/B/opcode fields, is_if, is_bra and a reg-direct flag. It is shared with the datapath decoder.

Test Plan:
1. Reset, then ena=1 and f_ack=1 held; f_dti=16'h7C01. pha cycles 0,1,2,3,0; ireg==16'h7C01 after the first phase-2 edge; all outputs 0 before that.
2. Stall: at pha==2 hold f_ack=0 for 5 cycles. pha stays 2, f_stb=1, ireg unchanged; on the f_ack=1 edge, pha goes to 3 and ireg latches.
3. Writeback: ireg=16'h0401 (SET B?, A-field reg 0), CC=1. rwe pulses 1 for exactly one cycle after phase 0 with rwa=0. Repeat with CC=0: rwe stays 0.
4. Skip: opc=4'hC, CC=0 in phase 0. skp=1; the next fetch of 16'h1234 latches 16'h0001 and skp clears; the following fetch latches normally.
5. wpc=1 together with skp=1 in phase 2. ireg=16'h0001, skp=0, and only one word is squashed.
6. Async reset asserted mid-stall at pha==2. All outputs go to 0 immediately, without a clock edge; after release, the sequence resumes from pha 0.

Source files
------------

// File: rtl/dcpu16_pkg.sv
// rtl/dcpu16_pkg.sv - shared widths, constants and phase encoding for the DCPU-16 control slice
package dcpu16_pkg;

    localparam int DEF_DW  = 16;
    localparam int DEF_OPW = 4;
    localparam int DEF_FW  = 6;
    localparam int DEF_RAW = 3;

    // SET A,A: harmless word used in place of a squashed instruction
    localparam logic [15:0] DEF_NOPI     = 16'h0001;
    // A-field value naming the PC as destination
    localparam logic [5:0]  DEF_BRA_CODE = 6'h10;
    // Opcodes from here up to all-ones are the IF-class conditionals
    localparam logic [3:0]  DEF_IFBASE   = 4'hC;

    typedef enum logic [1:0] {
        PH_EXA = 2'd0,
        PH_EXB = 2'd1,
        PH_FET = 2'd2,
        PH_DEC = 2'd3
    } phase_t;

    // Four-phase ring, 3 wraps back to 0
    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/dcpu16_ctlx_dec.sv
// rtl/dcpu16_ctlx_dec.sv - combinational instruction field splitter
module dcpu16_ctlx_dec
    import dcpu16_pkg::*;
#(
    parameter int              OPW      = DEF_OPW,
    parameter int              FW       = DEF_FW,
    parameter int              RAW      = DEF_RAW,
    parameter logic [FW-1:0]   BRA_CODE = DEF_BRA_CODE,
    parameter logic [OPW-1:0]  IFBASE   = DEF_IFBASE
) (
    // Opcode, full A field and the register-address bits of B
    input  logic [OPW+FW+RAW-1:0] iw,
    output logic [OPW-1:0]        op,
    output logic [RAW-1:0]        a_reg,
    output logic [RAW-1:0]        b_reg,
    output logic                  is_if,
    output logic                  is_bra,
    output logic                  a_rdir
);

    logic [FW-1:0] a_fld;

    assign op     = iw[OPW-1:0];
    assign a_fld  = iw[OPW+FW-1:OPW];
    assign b_reg  = iw[OPW+FW+RAW-1:OPW+FW];
    assign a_reg  = a_fld[RAW-1:0];

    // Conditionals occupy the top of the opcode space
    assign is_if  = (op >= IFBASE);
    // Branch detection compares the whole A field, not just the register bits
    assign is_bra = (a_fld == BRA_CODE);
    // A names a register directly only when the bits above the address are clear
    assign a_rdir = (a_fld[FW-1:RAW] == '0);

endmodule

// File: rtl/dcpu16_ctlx.sv
// rtl/dcpu16_ctlx.sv - four-phase control sequencer with fetch handshake and conditional skip
module dcpu16_ctlx
    import dcpu16_pkg::*;
#(
    parameter int              DW       = DEF_DW,
    parameter int              OPW      = DEF_OPW,
    parameter int              FW       = DEF_FW,
    parameter int              RAW      = DEF_RAW,
    parameter logic [DW-1:0]   NOPI     = DEF_NOPI,
    parameter logic [FW-1:0]   BRA_CODE = DEF_BRA_CODE,
    parameter logic [OPW-1:0]  IFBASE   = DEF_IFBASE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [DW-1:0]   f_dti,
    input  logic            f_ack,
    output logic            f_stb,
    input  logic            CC,
    input  logic            wpc,
    output logic [DW-1:0]   ireg,
    output logic [1:0]      pha,
    output logic [OPW-1:0]  opc,
    output logic [RAW-1:0]  rra,
    output logic [RAW-1:0]  rwa,
    output logic            rwe,
    output logic            bra,
    output logic            skp
);

    phase_t           pha_q;
    logic             adv;
    logic             opc_if;
    logic [RAW-1:0]   pnd_rwa;
    logic             pnd_rwe;

    logic [OPW-1:0]   d_op;
    logic [RAW-1:0]   d_a_reg;
    logic [RAW-1:0]   d_b_reg;
    logic             d_is_if;
    logic             d_is_bra;
    logic             d_a_rdir;

    dcpu16_ctlx_dec #(
        .OPW      (OPW),
        .FW       (FW),
        .RAW      (RAW),
        .BRA_CODE (BRA_CODE),
        .IFBASE   (IFBASE)
    ) u_dec (
        .iw     (ireg[OPW+FW+RAW-1:0]),
        .op     (d_op),
        .a_reg  (d_a_reg),
        .b_reg  (d_b_reg),
        .is_if  (d_is_if),
        .is_bra (d_is_bra),
        .a_rdir (d_a_rdir)
    );

    // Fetch phase waits for the bus; ena low freezes everything including the wait
    assign adv   = ena & ~((pha_q == PH_FET) & ~f_ack);
    assign f_stb = (pha_q == PH_FET);
    assign pha   = pha_q;

    // Phase sequencer, instruction latch, operand addressing and staged writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pha_q   <= PH_EXA;
            ireg    <= '0;
            opc     <= '0;
            opc_if  <= 1'b0;
            rra     <= '0;
            rwa     <= '0;
            rwe     <= 1'b0;
            bra     <= 1'b0;
            skp     <= 1'b0;
            pnd_rwa <= '0;
            pnd_rwe <= 1'b0;
        end else if (adv) begin
            pha_q <= next_phase(pha_q);
            rwe   <= 1'b0;
            // Even phases present B to the register file, odd phases present A
            if (pha_q == PH_EXA || pha_q == PH_FET)
                rra <= d_b_reg;
            else
                rra <= d_a_reg;

            case (pha_q)
                PH_EXA: begin
                    // Retire the write staged last round, gated by the condition and a pending skip
                    rwa     <= pnd_rwa;
                    rwe     <= pnd_rwe & CC & ~skp;
                    pnd_rwa <= d_a_reg;
                    pnd_rwe <= d_a_rdir & (opc != '0) & ~opc_if;
                    // A failed conditional drops the next fetched word
                    if (opc_if && !CC)
                        skp <= 1'b1;
                end
                PH_FET: begin
                    // A taken branch or a pending skip both replace the word with a NOP;
                    // together they still cost only one word
                    ireg   <= (wpc || skp) ? NOPI : f_dti;
                    opc    <= d_op;
                    opc_if <= d_is_if;
                    bra    <= d_is_bra;
                    if (skp)
                        skp <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcpu16_ctlx.sv
// tb/tb_dcpu16_ctlx.sv - self-checking bench for dcpu16_ctlx
module tb_dcpu16_ctlx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic [15:0] f_dti = 16'h0;
    logic        f_ack = 1'b0;
    logic        f_stb;
    logic        CC = 1'b0;
    logic        wpc = 1'b0;
    logic [15:0] ireg;
    logic [1:0]  pha;
    logic [3:0]  opc;
    logic [2:0]  rra;
    logic [2:0]  rwa;
    logic        rwe;
    logic        bra;
    logic        skp;

    int total = 0;
    int bad   = 0;

    // Reference state, kept as plain integers
    int m_pha, m_ireg, m_opc, m_rra, m_rwa, m_rwe, m_bra, m_skp, m_pwa, m_pwe;

    typedef struct {
        logic        ena;
        logic        ack;
        logic [15:0] dti;
        logic [1:0]  e_pha;
        logic [15:0] e_ireg;
        logic        e_stb;
    } vec_t;

    vec_t tbl[16];

    dcpu16_ctlx dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .f_dti (f_dti),
        .f_ack (f_ack),
        .f_stb (f_stb),
        .CC    (CC),
        .wpc   (wpc),
        .ireg  (ireg),
        .pha   (pha),
        .opc   (opc),
        .rra   (rra),
        .rwa   (rwa),
        .rwe   (rwe),
        .bra   (bra),
        .skp   (skp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic model_reset();
        m_pha = 0; m_ireg = 0; m_opc = 0; m_rra = 0; m_rwa = 0;
        m_rwe = 0; m_bra = 0; m_skp = 0; m_pwa = 0; m_pwe = 0;
    endtask

    // One clock of the spec rules, using inputs present before the edge
    task automatic model_step();
        int op_cur, a_cur, b_cur;
        if (!ena) return;
        if (m_pha == 2 && !f_ack) return;
        op_cur = m_ireg % 16;
        a_cur  = (m_ireg / 16) % 64;
        b_cur  = m_ireg / 1024;
        m_rra  = (m_pha % 2 == 0) ? (b_cur % 8) : (a_cur % 8);
        m_rwe  = 0;
        if (m_pha == 0) begin
            m_rwe = (m_pwe != 0 && CC && m_skp == 0) ? 1 : 0;
            m_rwa = m_pwa;
            m_pwa = a_cur % 8;
            m_pwe = (a_cur < 8 && m_opc != 0 && m_opc < 12) ? 1 : 0;
            if (m_opc >= 12 && !CC) m_skp = 1;
        end else if (m_pha == 2) begin
            m_opc  = op_cur;
            m_bra  = (a_cur == 16) ? 1 : 0;
            m_ireg = (wpc || m_skp != 0) ? 1 : int'(f_dti);
            m_skp  = 0;
        end
        m_pha = (m_pha + 1) % 4;
    endtask

    task automatic wb_test(input logic cc, input int exp_cnt);
        int cnt, at;
        do_reset();
        ena = 1'b1; f_ack = 1'b1; CC = cc; wpc = 1'b0; f_dti = 16'h0401;
        cnt = 0; at = -1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (rwe) begin
                cnt++;
                at = k;
            end
        end
        chk("wb_pulse_count", cnt, exp_cnt);
        chk("wb_pulse_edge", at, (exp_cnt != 0) ? 13 : -1);
        chk("wb_rwa", rwa, 0);
    endtask

    task automatic skip_test(input logic wpc_at_fetch, input string tag);
        do_reset();
        ena = 1'b1; f_ack = 1'b1; CC = 1'b0; wpc = 1'b0; f_dti = 16'h000C;
        for (int k = 1; k <= 3; k++) tick();
        chk({tag, "_first_fetch"}, ireg, 16'h000C);
        f_dti = 16'h1234;
        for (int k = 4; k <= 8; k++) tick();
        chk({tag, "_skp_before"}, skp, 0);
        tick();
        chk({tag, "_skp_set"}, skp, 1);
        tick();
        wpc = wpc_at_fetch;
        tick();
        wpc = 1'b0;
        chk({tag, "_squashed"}, ireg, 16'h0001);
        chk({tag, "_skp_clear"}, skp, 0);
        for (int k = 12; k <= 15; k++) tick();
        chk({tag, "_next_fetch"}, ireg, 16'h1234);
        chk({tag, "_skp_idle"}, skp, 0);
    endtask

    initial begin
        // Bring-up and stall vectors
        tbl[0]  = '{1'b1, 1'b1, 16'h7C01, 2'd1, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 16'h7C01, 2'd2, 16'h0000, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 16'h7C01, 2'd3, 16'h7C01, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 16'h7C01, 2'd0, 16'h7C01, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 16'h7C01, 2'd1, 16'h7C01, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 16'h7C01, 2'd2, 16'h7C01, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 16'h1111, 2'd2, 16'h7C01, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 16'h1111, 2'd2, 16'h7C01, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 16'h1111, 2'd2, 16'h7C01, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 16'h1111, 2'd2, 16'h7C01, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 16'h1111, 2'd2, 16'h7C01, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 16'h1111, 2'd2, 16'h7C01, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 16'h1111, 2'd3, 16'h1111, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 16'h1111, 2'd0, 16'h1111, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 16'h1111, 2'd0, 16'h1111, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 16'h2222, 2'd1, 16'h1111, 1'b0};

        do_reset();
        #1;
        chk("rst_pha", pha, 0);
        chk("rst_ireg", ireg, 0);
        chk("rst_opc", opc, 0);
        chk("rst_rra", rra, 0);
        chk("rst_rwa", rwa, 0);
        chk("rst_rwe", rwe, 0);
        chk("rst_bra", bra, 0);
        chk("rst_skp", skp, 0);
        chk("rst_stb", f_stb, 0);

        for (int i = 0; i < 16; i++) begin
            ena = tbl[i].ena; f_ack = tbl[i].ack; f_dti = tbl[i].dti;
            tick();
            chk($sformatf("vec%0d_pha", i), pha, tbl[i].e_pha);
            chk($sformatf("vec%0d_ireg", i), ireg, tbl[i].e_ireg);
            chk($sformatf("vec%0d_stb", i), f_stb, tbl[i].e_stb);
            chk($sformatf("vec%0d_rwe", i), rwe, 0);
        end

        wb_test(1'b1, 1);
        wb_test(1'b0, 0);
        skip_test(1'b0, "skip");
        skip_test(1'b1, "skip_wpc");

        // Asynchronous reset while stalled in the fetch phase
        do_reset();
        ena = 1'b1; f_ack = 1'b1; CC = 1'b1; wpc = 1'b0; f_dti = 16'h0401;
        for (int k = 1; k <= 10; k++) tick();
        f_ack = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("stall_pha", pha, 2);
        chk("stall_stb", f_stb, 1);
        chk("stall_ireg", ireg, 16'h0401);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pha", pha, 0);
        chk("arst_ireg", ireg, 0);
        chk("arst_opc", opc, 0);
        chk("arst_rra", rra, 0);
        chk("arst_stb", f_stb, 0);
        chk("arst_skp", skp, 0);
        @(negedge clk);
        rst = 1'b1;
        f_ack = 1'b1;
        tick();
        chk("arst_resume_pha", pha, 1);
        chk("arst_resume_ireg", ireg, 0);

        // Randomised run against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] w;
            w = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 7) == 0) w[9:4] = 6'h10;
            if ($urandom_range(0, 5) == 0) w[3:0] = 4'($urandom_range(12, 15));
            f_dti = w;
            ena   = ($urandom_range(0, 9) != 0);
            f_ack = ($urandom_range(0, 3) != 0);
            CC    = 1'($urandom_range(0, 1));
            wpc   = ($urandom_range(0, 7) == 0);
            model_step();
            tick();
            chk("rnd_pha", pha, m_pha);
            chk("rnd_ireg", ireg, m_ireg);
            chk("rnd_opc", opc, m_opc);
            chk("rnd_rra", rra, m_rra);
            chk("rnd_rwa", rwa, m_rwa);
            chk("rnd_rwe", rwe, m_rwe);
            chk("rnd_bra", bra, m_bra);
            chk("rnd_skp", skp, m_skp);
            chk("rnd_stb", f_stb, (m_pha == 2) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
